// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding and helpers for the UART byte receiver.
package uart_pkg;
  localparam int DATA_BITS = 8;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_e;
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction
endpackage

// File: rtl/uart_rx_byte_sync2.sv
// sync2: two-flop synchroniser for an asynchronous pin with a configurable reset value.
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [1:0] ff_q, ff_d;
  always_comb ff_d = {ff_q[0], d};
  always_ff @(posedge clk) begin
    if (rst) ff_q <= {2{RST_VAL}};
    else ff_q <= ff_d;
  end
  assign q = ff_q[1];
endmodule

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 UART receiver with centre sampling; UART_RX_PARITY_EN selects 8E1 with parity_error.
module uart_rx_byte import uart_pkg::*; #(
  parameter int CLK_HZ       = 12000000,
  parameter int BAUD         = 115200,
  parameter int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD)
) (
  input  logic                 clk,
  input  logic                 RESET,
  input  logic                 UART_RX,
  output logic [DATA_BITS-1:0] data,
  output logic                 send,
  output logic                 framing_error
`ifdef UART_RX_PARITY_EN
  , output logic               parity_error
`endif
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_M1 = TW'(CLKS_PER_BIT / 2 - 1);
  if (CLKS_PER_BIT < 4) begin : g_cpb_check
    $error("CLKS_PER_BIT must be >= 4");
  end
  logic rx_s;
  state_e state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0] bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d, data_q, data_d;
  logic send_q, send_d, ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic pbad_q, pbad_d, perr_q, perr_d;
`endif
  sync2 #(.RST_VAL(1'b1)) u_sync (.clk(clk), .rst(RESET), .d(UART_RX), .q(rx_s));
  always_comb begin
    state_d = state_q;
    timer_d = timer_q + 1'b1;
    bit_d = bit_q;
    shreg_d = shreg_q;
    data_d = data_q;
    send_d = 1'b0;
    ferr_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    pbad_d = pbad_q;
    perr_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        timer_d = '0;
        state_d = rx_s ? IDLE : START;
      end
      // a start bit still low at its centre is genuine, otherwise it was a glitch
      START: if (timer_q == HALF_M1) begin
        timer_d = '0;
        bit_d = '0;
        state_d = rx_s ? IDLE : DATA;
      end
      DATA: if (timer_q == LAST) begin
        timer_d = '0;
        shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
        bit_d = bit_q + 1'b1;
`ifdef UART_RX_PARITY_EN
        if (bit_q == 3'(DATA_BITS - 1)) state_d = PARITY;
`else
        if (bit_q == 3'(DATA_BITS - 1)) state_d = STOP;
`endif
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (timer_q == LAST) begin
        timer_d = '0;
        pbad_d = ^{shreg_q, rx_s};
        state_d = STOP;
      end
`endif
      STOP: if (timer_q == LAST) begin
        timer_d = '0;
        state_d = rx_s ? IDLE : BREAK;
        ferr_d = !rx_s;
`ifdef UART_RX_PARITY_EN
        send_d = rx_s && !pbad_q;
        perr_d = rx_s && pbad_q;
        data_d = (rx_s && !pbad_q) ? shreg_q : data_q;
`else
        send_d = rx_s;
        data_d = rx_s ? shreg_q : data_q;
`endif
      end
      BREAK: begin
        timer_d = '0;
        state_d = rx_s ? IDLE : BREAK;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q <= IDLE;
      timer_q <= '0;
      bit_q <= '0;
      shreg_q <= '0;
      data_q <= '0;
      send_q <= 1'b0;
      ferr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pbad_q <= 1'b0;
      perr_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      bit_q <= bit_d;
      shreg_q <= shreg_d;
      data_q <= data_d;
      send_q <= send_d;
      ferr_q <= ferr_d;
`ifdef UART_RX_PARITY_EN
      pbad_q <= pbad_d;
      perr_q <= perr_d;
`endif
    end
  end
  assign data = data_q;
  assign send = send_q;
  assign framing_error = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_error = perr_q;
`endif
endmodule
